// File: rtl/mcycle_defs_pkg.sv
// Shared definitions for the multi-cycle mul/div sequencer:
// the sequencer state encoding, the MCycleOp codes and the RISC-V M-extension
// funct3 values that decide which result word goes back to Execute.
package mcycle_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } mc_state_t;

    // MCycleOp codes; bit 1 distinguishes divide from multiply
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;

    // funct3 values of the M extension
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // True for the two divide op codes
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mcycle_sequencer_result_sel.sv
// Combinational result-word select for the mul/div sequencer.
// The low word carries the low product or quotient, the high word the high
// product or remainder; funct3 decides which one the instruction wants.
module mcycle_result_sel
    import mcycle_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] word_lo,
    input  logic [WIDTH-1:0] word_hi,
    output logic [WIDTH-1:0] word_out
);

    // mulh*, rem and remu take the high word; mul, div and divu the low word
    always_comb begin
        word_out = word_lo;
        case (funct3)
            F3_MULH, F3_MULHSU, F3_MULHU, F3_REM, F3_REMU: word_out = word_hi;
            default:                                       word_out = word_lo;
        endcase
    end

endmodule

// File: rtl/mcycle_sequencer.sv
// Sequencer between the Execute stage and the shared multi-cycle mul/div unit.
// It latches the request, fires a single start pulse, stalls the pipeline
// while the unit works, returns the selected result word as a one-cycle
// pulse, and drains an operation that was flushed while in flight.
// Optional feature macro: MCYCLE_DIVZERO_FAST_EN -- when defined, a divide by
// zero skips the unit and returns the RISC-V defined results in two cycles.
module mcycle_sequencer
    import mcycle_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             MCycleStart,
    input  logic [1:0]       MCycleOp,
    input  logic [2:0]       Funct3,
    input  logic             Flush,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic             StallReq,
    output logic [WIDTH-1:0] Result,
    output logic             ResultValid,
    output logic             UnitStart,
    output logic [1:0]       UnitOp,
    output logic [WIDTH-1:0] UnitA,
    output logic [WIDTH-1:0] UnitB,
    input  logic             UnitDone,
    input  logic [WIDTH-1:0] UnitResult1,
    input  logic [WIDTH-1:0] UnitResult2
);

    mc_state_t        state;
    mc_state_t        state_next;
    logic [2:0]       funct3_q;
    logic             stall;
    logic             result_pulse;
    logic             launch;
    logic             result_load;
    logic             div_by_zero;
    logic [2:0]       sel_funct3;
    logic [WIDTH-1:0] sel_lo;
    logic [WIDTH-1:0] sel_hi;
    logic [WIDTH-1:0] sel_word;

`ifdef MCYCLE_DIVZERO_FAST_EN
    // In IDLE the only load is the bypass, so the select sees the live request
    // and the architectural divide-by-zero words instead of the unit outputs
    assign div_by_zero = op_is_div(MCycleOp) && (Operand2 == '0);
    assign sel_funct3  = (state == ST_IDLE) ? Funct3 : funct3_q;
    assign sel_lo      = (state == ST_IDLE) ? {WIDTH{1'b1}} : UnitResult1;
    assign sel_hi      = (state == ST_IDLE) ? Operand1 : UnitResult2;
`else
    assign div_by_zero = 1'b0;
    assign sel_funct3  = funct3_q;
    assign sel_lo      = UnitResult1;
    assign sel_hi      = UnitResult2;
`endif

    mcycle_result_sel #(
        .WIDTH(WIDTH)
    ) u_result_sel (
        .funct3  (sel_funct3),
        .word_lo (sel_lo),
        .word_hi (sel_hi),
        .word_out(sel_word)
    );

    // Next-state, stall and result-valid decode for the four-state sequencer
    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        result_pulse = 1'b0;
        launch       = 1'b0;
        result_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = MCycleStart & ~Flush;
                if (MCycleStart && !Flush) begin
                    if (div_by_zero) begin
                        result_load = 1'b1;
                        state_next  = ST_DONE;
                    end else begin
                        launch     = 1'b1;
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                stall = 1'b1;
                if (Flush) begin
                    state_next = ST_DRAIN;
                end else if (UnitDone) begin
                    result_load = 1'b1;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                result_pulse = ~Flush;
                state_next   = ST_IDLE;
            end
            ST_DRAIN: begin
                stall = MCycleStart;
                if (UnitDone) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The IDLE stall is combinational on the request, so it is gated with the
    // reset to keep every output low while the core is held in reset
    assign StallReq    = stall & RESETn;
    assign ResultValid = result_pulse;

    // Sequencer state register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand, op and funct3 latches plus the start pulse; these only move on
    // IDLE to RUN so the unit sees stable inputs for the whole operation
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            UnitOp    <= '0;
            UnitA     <= '0;
            UnitB     <= '0;
            funct3_q  <= '0;
            UnitStart <= 1'b0;
        end else begin
            UnitStart <= launch;
            if (launch) begin
                UnitOp   <= MCycleOp;
                UnitA    <= Operand1;
                UnitB    <= Operand2;
                funct3_q <= Funct3;
            end
        end
    end

    // Result register; holds the last delivered word until the next load
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            Result <= '0;
        end else if (result_load) begin
            Result <= sel_word;
        end
    end

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Directed testbench for mcycle_sequencer. The bench plays the role of the
// multi-cycle unit by hand, driving UnitDone and the result words with
// hand-computed products, quotients and remainders.
`timescale 1ns/1ps
module tb_mcycle_sequencer;

    logic        CLK;
    logic        RESETn;
    logic        MCycleStart;
    logic [1:0]  MCycleOp;
    logic [2:0]  Funct3;
    logic        Flush;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic        StallReq;
    logic [31:0] Result;
    logic        ResultValid;
    logic        UnitStart;
    logic [1:0]  UnitOp;
    logic [31:0] UnitA;
    logic [31:0] UnitB;
    logic        UnitDone;
    logic [31:0] UnitResult1;
    logic [31:0] UnitResult2;

    int checks;
    int errors;
    int start_count;
    int rv_count;
    logic [31:0] last_exp;

    mcycle_sequencer #(.WIDTH(32)) dut (
        .CLK(CLK), .RESETn(RESETn), .MCycleStart(MCycleStart), .MCycleOp(MCycleOp),
        .Funct3(Funct3), .Flush(Flush), .Operand1(Operand1), .Operand2(Operand2),
        .StallReq(StallReq), .Result(Result), .ResultValid(ResultValid),
        .UnitStart(UnitStart), .UnitOp(UnitOp), .UnitA(UnitA), .UnitB(UnitB),
        .UnitDone(UnitDone), .UnitResult1(UnitResult1), .UnitResult2(UnitResult2)
    );

    // Free-running 100 MHz clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Count start pulses and result pulses, sampled mid-cycle
    always @(negedge CLK) begin
        if (UnitStart === 1'b1) start_count++;
        if (ResultValid === 1'b1) rv_count++;
    end

    // Hard stop in case anything wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One complete operation through the unit with latency lat (start pulse in
    // cycle 1, UnitDone in cycle lat, ResultValid in cycle lat+1)
    task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] expv);
        int starts0;
        starts0 = start_count;
        MCycleStart = 1'b1; MCycleOp = op; Funct3 = f3; Operand1 = a; Operand2 = b;
        Flush = 1'b0; UnitDone = 1'b0;
        @(negedge CLK);
        checks++; if (StallReq !== 1'b1) begin errors++; $display("[TB] FAIL %s c0 StallReq got %b want 1", name, StallReq); end
        checks++; if (UnitStart !== 1'b0) begin errors++; $display("[TB] FAIL %s c0 UnitStart got %b want 0", name, UnitStart); end
        checks++; if (ResultValid !== 1'b0) begin errors++; $display("[TB] FAIL %s c0 ResultValid got %b want 0", name, ResultValid); end
        tick();
        Operand1 = ~a; Operand2 = ~b; MCycleOp = ~op; Funct3 = ~f3;
        @(negedge CLK);
        checks++; if (UnitStart !== 1'b1) begin errors++; $display("[TB] FAIL %s c1 UnitStart got %b want 1", name, UnitStart); end
        checks++; if (UnitA !== a) begin errors++; $display("[TB] FAIL %s c1 UnitA got %h want %h", name, UnitA, a); end
        checks++; if (UnitB !== b) begin errors++; $display("[TB] FAIL %s c1 UnitB got %h want %h", name, UnitB, b); end
        checks++; if (UnitOp !== op) begin errors++; $display("[TB] FAIL %s c1 UnitOp got %b want %b", name, UnitOp, op); end
        checks++; if (StallReq !== 1'b1) begin errors++; $display("[TB] FAIL %s c1 StallReq got %b want 1", name, StallReq); end
        for (int c = 2; c <= lat; c++) begin
            tick();
            if (c == lat) begin
                UnitDone = 1'b1; UnitResult1 = r1; UnitResult2 = r2;
            end
            @(negedge CLK);
            checks++; if (StallReq !== 1'b1) begin errors++; $display("[TB] FAIL %s c%0d StallReq got %b want 1", name, c, StallReq); end
            checks++; if (UnitStart !== 1'b0) begin errors++; $display("[TB] FAIL %s c%0d UnitStart got %b want 0", name, c, UnitStart); end
            checks++; if (ResultValid !== 1'b0) begin errors++; $display("[TB] FAIL %s c%0d ResultValid got %b want 0", name, c, ResultValid); end
            checks++; if (UnitA !== a) begin errors++; $display("[TB] FAIL %s c%0d UnitA held got %h want %h", name, c, UnitA, a); end
        end
        tick();
        UnitDone = 1'b0; UnitResult1 = 32'h5A5A5A5A; UnitResult2 = 32'hA5A5A5A5;
        @(negedge CLK);
        checks++; if (ResultValid !== 1'b1) begin errors++; $display("[TB] FAIL %s done ResultValid got %b want 1", name, ResultValid); end
        checks++; if (Result !== expv) begin errors++; $display("[TB] FAIL %s done Result got %h want %h", name, Result, expv); end
        checks++; if (StallReq !== 1'b0) begin errors++; $display("[TB] FAIL %s done StallReq got %b want 0", name, StallReq); end
        tick();
        MCycleStart = 1'b0; Flush = 1'b0;
        checks++; if (start_count - starts0 != 1) begin errors++; $display("[TB] FAIL %s start pulses got %0d want 1", name, start_count - starts0); end
        last_exp = expv;
    endtask

    task automatic test_reset();
        RESETn = 1'b0; MCycleStart = 1'b1; MCycleOp = 2'b00; Funct3 = 3'b000; Flush = 1'b0;
        Operand1 = 32'h11; Operand2 = 32'h22; UnitDone = 1'b0;
        UnitResult1 = 32'h0; UnitResult2 = 32'h0;
        start_count = 0; rv_count = 0; last_exp = 32'h0;
        #3;
        checks++; if (StallReq !== 1'b0) begin errors++; $display("[TB] FAIL reset StallReq got %b want 0", StallReq); end
        checks++; if (UnitStart !== 1'b0) begin errors++; $display("[TB] FAIL reset UnitStart got %b want 0", UnitStart); end
        checks++; if (ResultValid !== 1'b0) begin errors++; $display("[TB] FAIL reset ResultValid got %b want 0", ResultValid); end
        checks++; if (Result !== 32'h0) begin errors++; $display("[TB] FAIL reset Result got %h want 0", Result); end
        checks++; if ({UnitA, UnitB, UnitOp} !== 66'h0) begin errors++; $display("[TB] FAIL reset unit regs got %h %h %b want 0", UnitA, UnitB, UnitOp); end
        tick();
        tick();
        MCycleStart = 1'b0;
        RESETn = 1'b1;
        @(negedge CLK);
        checks++; if (StallReq !== 1'b0) begin errors++; $display("[TB] FAIL post-reset StallReq got %b want 0", StallReq); end
        tick();
    endtask

    task automatic test_mul();
        run_op("mul 7x-3", 2'b00, 3'b000, 32'd7, 32'hFFFFFFFD, 5, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB);
        @(negedge CLK);
        checks++; if (ResultValid !== 1'b0) begin errors++; $display("[TB] FAIL mul after ResultValid got %b want 0", ResultValid); end
        checks++; if (Result !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mul Result hold got %h want ffffffeb", Result); end
        tick();
    endtask

    task automatic test_rem_mulhu();
        run_op("rem 17%5", 2'b10, 3'b110, 32'd17, 32'd5, 4, 32'd3, 32'd2, 32'd2);
        run_op("mulhu", 2'b01, 3'b011, 32'h80000000, 32'd4, 3, 32'h0, 32'h2, 32'h2);
    endtask

    task automatic test_back_to_back();
        run_op("b2b div", 2'b10, 3'b100, 32'hFFFFFFEC, 32'd3, 3, 32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFFFFFA);
        run_op("b2b mulhsu", 2'b01, 3'b010, 32'hFFFFFFFF, 32'd2, 2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("b2b mulh", 2'b00, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 32'h1, 32'h0, 32'h0);
    endtask

    task automatic test_flush_run();
        int starts0;
        int rv0;
        starts0 = start_count; rv0 = rv_count;
        MCycleStart = 1'b1; MCycleOp = 2'b10; Funct3 = 3'b100; Operand1 = 32'd100; Operand2 = 32'd7;
        tick();
        @(negedge CLK);
        checks++; if (UnitStart !== 1'b1) begin errors++; $display("[TB] FAIL flush c1 UnitStart got %b want 1", UnitStart); end
        tick();
        Flush = 1'b1; MCycleStart = 1'b0;
        @(negedge CLK);
        checks++; if (StallReq !== 1'b1) begin errors++; $display("[TB] FAIL flush c2 StallReq got %b want 1", StallReq); end
        tick();
        Flush = 1'b0; MCycleStart = 1'b1; MCycleOp = 2'b01; Funct3 = 3'b011;
        Operand1 = 32'h80000000; Operand2 = 32'd4;
        for (int c = 3; c <= 5; c++) begin
            if (c == 5) begin
                UnitDone = 1'b1; UnitResult1 = 32'd14; UnitResult2 = 32'd2;
            end
            @(negedge CLK);
            checks++; if (StallReq !== 1'b1) begin errors++; $display("[TB] FAIL flush drain c%0d StallReq got %b want 1", c, StallReq); end
            checks++; if (UnitStart !== 1'b0) begin errors++; $display("[TB] FAIL flush drain c%0d UnitStart got %b want 0", c, UnitStart); end
            tick();
        end
        UnitDone = 1'b0;
        checks++; if (Result !== last_exp) begin errors++; $display("[TB] FAIL flush Result kept got %h want %h", Result, last_exp); end
        run_op("mulhu after drain", 2'b01, 3'b011, 32'h80000000, 32'd4, 3, 32'h0, 32'h2, 32'h2);
        checks++; if (start_count - starts0 != 2) begin errors++; $display("[TB] FAIL flush start pulses got %0d want 2", start_count - starts0); end
        checks++; if (rv_count - rv0 != 1) begin errors++; $display("[TB] FAIL flush result pulses got %0d want 1", rv_count - rv0); end
    endtask

    task automatic test_flush_done_same_cycle();
        int starts0;
        int rv0;
        starts0 = start_count; rv0 = rv_count;
        MCycleStart = 1'b1; MCycleOp = 2'b00; Funct3 = 3'b000; Operand1 = 32'd3; Operand2 = 32'd4;
        tick();
        tick();
        tick();
        Flush = 1'b1; UnitDone = 1'b1; UnitResult1 = 32'd12; UnitResult2 = 32'd0; MCycleStart = 1'b0;
        @(negedge CLK);
        checks++; if (StallReq !== 1'b1) begin errors++; $display("[TB] FAIL simul c3 StallReq got %b want 1", StallReq); end
        tick();
        Flush = 1'b0; UnitDone = 1'b0;
        @(negedge CLK);
        checks++; if (StallReq !== 1'b0) begin errors++; $display("[TB] FAIL simul drain idle-req StallReq got %b want 0", StallReq); end
        checks++; if (Result !== last_exp) begin errors++; $display("[TB] FAIL simul Result kept got %h want %h", Result, last_exp); end
        tick();
        MCycleStart = 1'b1; Flush = 1'b1;
        @(negedge CLK);
        checks++; if (StallReq !== 1'b1) begin errors++; $display("[TB] FAIL simul still draining StallReq got %b want 1", StallReq); end
        tick();
        MCycleStart = 1'b0; Flush = 1'b0; UnitDone = 1'b1;
        tick();
        UnitDone = 1'b0; MCycleStart = 1'b1; Flush = 1'b1;
        @(negedge CLK);
        checks++; if (StallReq !== 1'b0) begin errors++; $display("[TB] FAIL simul back in idle StallReq got %b want 0", StallReq); end
        tick();
        MCycleStart = 1'b0; Flush = 1'b0;
        @(negedge CLK);
        checks++; if (UnitStart !== 1'b0) begin errors++; $display("[TB] FAIL simul UnitStart got %b want 0", UnitStart); end
        checks++; if (rv_count != rv0) begin errors++; $display("[TB] FAIL simul result pulses got %0d want 0", rv_count - rv0); end
        checks++; if (start_count - starts0 != 1) begin errors++; $display("[TB] FAIL simul start pulses got %0d want 1", start_count - starts0); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        MCycleStart = 1'b1; MCycleOp = 2'b11; Funct3 = 3'b101; Operand1 = 32'd50; Operand2 = 32'd5;
        tick();
        @(negedge CLK);
        checks++; if (UnitStart !== 1'b1) begin errors++; $display("[TB] FAIL rst-mid c1 UnitStart got %b want 1", UnitStart); end
        tick();
        RESETn = 1'b0;
        #1;
        checks++; if (StallReq !== 1'b0) begin errors++; $display("[TB] FAIL rst-mid StallReq got %b want 0", StallReq); end
        checks++; if (Result !== 32'h0) begin errors++; $display("[TB] FAIL rst-mid Result got %h want 0", Result); end
        checks++; if ({UnitStart, ResultValid} !== 2'b00) begin errors++; $display("[TB] FAIL rst-mid pulses got %b%b want 00", UnitStart, ResultValid); end
        checks++; if ({UnitA, UnitB, UnitOp} !== 66'h0) begin errors++; $display("[TB] FAIL rst-mid unit regs got %h %h %b want 0", UnitA, UnitB, UnitOp); end
        tick();
        RESETn = 1'b1; MCycleStart = 1'b0;
        tick();
        UnitDone = 1'b1; UnitResult1 = 32'd10; UnitResult2 = 32'd0;
        @(negedge CLK);
        checks++; if (StallReq !== 1'b0) begin errors++; $display("[TB] FAIL stale done StallReq got %b want 0", StallReq); end
        tick();
        UnitDone = 1'b0;
        @(negedge CLK);
        checks++; if (ResultValid !== 1'b0) begin errors++; $display("[TB] FAIL stale done ResultValid got %b want 0", ResultValid); end
        checks++; if (Result !== 32'h0) begin errors++; $display("[TB] FAIL stale done Result got %h want 0", Result); end
        tick();
        run_op("remu after reset", 2'b11, 3'b111, 32'd50, 32'd7, 2, 32'd7, 32'd1, 32'd1);
    endtask

    task automatic test_divzero();
`ifdef MCYCLE_DIVZERO_FAST_EN
        logic [2:0]  f3;
        logic [31:0] expv;
        int starts0;
        starts0 = start_count;
        for (int i = 0; i < 2; i++) begin
            f3   = (i == 0) ? 3'b101 : 3'b111;
            expv = (i == 0) ? 32'hFFFFFFFF : 32'h00001234;
            MCycleStart = 1'b1; MCycleOp = 2'b11; Funct3 = f3; Operand1 = 32'h1234; Operand2 = 32'h0;
            @(negedge CLK);
            checks++; if (StallReq !== 1'b1) begin errors++; $display("[TB] FAIL divzero%0d c0 StallReq got %b want 1", i, StallReq); end
            tick();
            @(negedge CLK);
            checks++; if (ResultValid !== 1'b1) begin errors++; $display("[TB] FAIL divzero%0d c1 ResultValid got %b want 1", i, ResultValid); end
            checks++; if (Result !== expv) begin errors++; $display("[TB] FAIL divzero%0d c1 Result got %h want %h", i, Result, expv); end
            checks++; if (StallReq !== 1'b0) begin errors++; $display("[TB] FAIL divzero%0d c1 StallReq got %b want 0", i, StallReq); end
            tick();
            MCycleStart = 1'b0;
            @(negedge CLK);
            checks++; if (ResultValid !== 1'b0) begin errors++; $display("[TB] FAIL divzero%0d c2 ResultValid got %b want 0", i, ResultValid); end
            tick();
        end
        checks++; if (start_count != starts0) begin errors++; $display("[TB] FAIL divzero start pulses got %0d want 0", start_count - starts0); end
`else
        run_op("divu by 0 via unit", 2'b11, 3'b101, 32'h1234, 32'h0, 3, 32'h0BAD0001, 32'h1234, 32'h0BAD0001);
        run_op("remu by 0 via unit", 2'b11, 3'b111, 32'h1234, 32'h0, 3, 32'hFFFFFFFF, 32'h00C0FFEE, 32'h00C0FFEE);
`endif
    endtask

    // Scenario sequence
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mul();
        test_rem_mulhu();
        test_back_to_back();
        test_flush_run();
        test_flush_done_same_cycle();
        test_reset_mid_op();
        test_divzero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcycle_sequencer.md
# mcycle_sequencer

Sequences the shared multi-cycle multiply/divide unit (MCycle) on behalf of the Execute stage. Accepts the Decoder's `MCycleStart`/`MCycleOp` request, registers operands, issues a single start pulse to the unit, and raises a pipeline stall while the unit is busy. It then returns the correct result word for mul/mulh*/div*/rem*, and it also handles flushes that arrive while an operation is in flight.

## Interface
- `WIDTH`, 32: operand and result width.
- `CLK`  in  1  core clock; all state updates on rising edge.
- `RESETn`  in  1  asynchronous, active-low reset.
- `MCycleStart`  in  1  E-stage request, from the Decoder, qualified by the E-stage valid.
- `MCycleOp`  in  2  00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
- `Funct3`  in  3  E-stage funct3; selects the result word.
- `Flush`  in  1  E-stage flush; kills the current request or result.
- `Operand1`, `Operand2`  in  WIDTH  rs1/rs2 values after forwarding.
- `StallReq`  out  1  to the hazard unit; stalls F/D/E.
- `Result`  out  WIDTH  selected result; valid when `ResultValid`=1.
- `ResultValid`  out  1  one-cycle pulse; E-stage consumes `Result`.
- `UnitStart`  out  1  one-cycle start pulse to MCycle.
- `UnitOp`  out  2  registered copy of `MCycleOp`.
- `UnitA`, `UnitB`  out  WIDTH  registered operands, held stable from `UnitStart` until `UnitDone`.
- `UnitDone`  in  1  one-cycle completion pulse from MCycle.
- `UnitResult1`, `UnitResult2`  in  WIDTH  low product or quotient / high product or remainder; valid with `UnitDone`.

## Operation
- States: IDLE, RUN, DONE, DRAIN. Reset → IDLE.
- Every register and output is cleared to 0 while `RESETn`=0. This includes `StallReq`, `UnitStart`, `ResultValid` and `Result`.
- **IDLE:**
  - `MCycleStart`=1 and `Flush`=0 → latch `MCycleOp`, `Funct3` and the operands, then go to RUN.
  - `StallReq` = `MCycleStart & ~Flush`, combinationally, in the same cycle.
- **RUN:**
  - `UnitStart`=1 in the first RUN cycle only. `StallReq`=1 throughout.
  - `UnitDone` → latch the selected word into `Result`, go to DONE.
  - `Flush` → go to DRAIN. `Flush` takes priority over a simultaneous `UnitDone`.
- **DONE:**
  - `ResultValid` = `~Flush`. `StallReq`=0. Unconditionally go to IDLE.
  - `MCycleStart` is ignored in DONE, because it belongs to the same instruction and must not restart the unit.
- **DRAIN:**
  - Waits for the killed operation's `UnitDone`, then goes to IDLE. The result is discarded.
  - `StallReq` = `MCycleStart`, so a new mul/div waits for the unit to free.
- **Word select:**
  - Funct3 000 (mul), 100 (div) and 101 (divu) → `UnitResult1`.
  - Funct3 001, 010 and 011 (mulh*), 110 (rem) and 111 (remu) → `UnitResult2`.
  - mulhsu follows the `MCycleOp` encoding, which is unsigned.
- **Reset mid-operation:** forces IDLE immediately. A later `UnitDone` from the stale operation arrives in IDLE and is ignored.

## Timing
- Normal op: cycle 0 request with `StallReq`=1; cycle 1 `UnitStart`; cycle N `UnitDone`; cycle N+1 `ResultValid`=1 with `StallReq`=0.
- Total latency = unit latency + 2 cycles.
- Back-to-back mul/div: the second request is seen in IDLE at cycle N+2, so there is no gap beyond the DONE cycle.
- `UnitA`, `UnitB` and `UnitOp` change only on IDLE→RUN.
- `Result` holds its value until the next latch.

## Configuration
- `MCYCLE_DIVZERO_FAST_EN` defined:
  - A div op (`MCycleOp[1]`=1) with `Operand2`=0 bypasses the unit. No `UnitStart` is issued.
  - The block goes IDLE→DONE in one cycle with the RISC-V results: quotient all-ones (0xFFFFFFFF), remainder = `Operand1`.
  - Total latency is 2 cycles.
- Undefined: divide-by-zero goes through the unit like any other op, and the unit's result is returned unmodified.

## Structure
- Shared package/header `mcycle_defs` holds:
  - the state encoding;
  - the `MCycleOp` codes;
  - the Funct3 constants for mul/mulh/mulhsu/mulhu/div/divu/rem/remu.
- Sub-module `mcycle_result_sel` is the combinational word select: Funct3 and both unit results in, one word out.
- The FSM, the operand/op latches and the divide-by-zero bypass stay in the top level.

## Test plan
- **mul:** `MCycleOp`=00, Funct3=000, 7×(−3) with a unit latency of 5 → `StallReq` high for cycles 0–5. `UnitStart` is high only in cycle 1. Cycle 6 has `ResultValid`=1 and `Result`=0xFFFFFFEB.
- **rem:** `MCycleOp`=10, Funct3=110, 17 rem 5 → `Result`=2, taken from `UnitResult2`. Exactly one `UnitStart` pulse.
- **Flush in RUN:** `Flush` at cycle 2, and a new request is held high before `UnitDone` → DRAIN is entered and `StallReq` stays high. The first `UnitDone` produces no `ResultValid`. The new op's `UnitStart` follows the drain.
- **Divide-by-zero, macro on:** divu 0x1234 by 0 → no `UnitStart`. Cycle 1 has `ResultValid` with 0xFFFFFFFF. For remu, `Result`=0x1234. With the macro off, the op is dispatched to the unit.
- **Reset mid-operation:** `RESETn` low in RUN → all outputs are 0 at once and the state is IDLE. A stale `UnitDone` afterwards is ignored.
- **Simultaneous `Flush` and `UnitDone` in RUN** → the block goes to DRAIN and then IDLE on the next `UnitDone`. `ResultValid` never asserts.
